// File: rtl/spi_reg_bank.sv
// Purpose : byte-framed read/write register bank behind an SPI slave, framed by chip select.
// Latency : write lands 1 cycle after i_RX_DV; o_TX_DV/o_TX_Byte 1 cycle after i_RX_DV; CS edges seen 3 cycles after the pin.
// Backpress: none; every i_RX_DV pulse is consumed, including pulses on consecutive cycles.
module spi_reg_bank #(
  parameter int NUM_REGS = 8,   // power of two, 2..16
  parameter int ADDR_W   = 3    // log2(NUM_REGS)
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_L,
  input  logic                  i_RX_DV,
  input  logic [7:0]            i_RX_Byte,
  input  logic                  i_SPI_CS_n,
  output logic                  o_TX_DV,
  output logic [7:0]            o_TX_Byte,
  output logic [8*NUM_REGS-1:0] o_regs,
  output logic                  o_wr_strobe,
  output logic [ADDR_W-1:0]     o_wr_addr,
  output logic                  o_cmd_err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CMD     = 3'd1,
    WRITE   = 3'd2,
    READ    = 3'd3,
    DISCARD = 3'd4
  } state_t;

  state_t            state;
  logic              cs_meta;
  logic              cs_sync;
  logic              cs_prev;
  logic              cs_rise;
  logic              cs_fall;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] addr_nxt;
  logic [7:0]        regs [NUM_REGS];

  // Command byte fields: bit 7 selects read, low bits give the start address,
  // everything in between is reserved and must be zero.
  logic              cmd_rd;
  logic [ADDR_W-1:0] cmd_addr;
  logic              cmd_rsvd;

  assign cmd_rd   = i_RX_Byte[7];
  assign cmd_addr = i_RX_Byte[ADDR_W-1:0];
  assign cmd_rsvd = |i_RX_Byte[6:ADDR_W];
  // Address arithmetic wraps naturally at ADDR_W bits.
  assign addr_nxt = addr + ADDR_W'(1);

  assign cs_rise = cs_sync & ~cs_prev;
  assign cs_fall = ~cs_sync & cs_prev;

  // Two-flop synchroniser for the raw CS pin plus a third flop for edge detection;
  // all idle high so reset never looks like a deselect edge.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      cs_meta <= 1'b1;
      cs_sync <= 1'b1;
      cs_prev <= 1'b1;
    end else begin
      cs_meta <= i_SPI_CS_n;
      cs_sync <= cs_meta;
      cs_prev <= cs_sync;
    end
  end

  // Transaction FSM, register array and registered outputs. A byte arriving in
  // the same cycle as a CS edge is processed first; the CS edge then overrides
  // the next state.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state       <= IDLE;
      addr        <= '0;
      o_TX_DV     <= 1'b0;
      o_TX_Byte   <= 8'h00;
      o_wr_strobe <= 1'b0;
      o_wr_addr   <= '0;
      o_cmd_err   <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= 8'h00;
      end
    end else begin
      o_TX_DV     <= 1'b0;
      o_wr_strobe <= 1'b0;

      case (state)
        IDLE: begin
          if (cs_fall) begin
            state <= CMD;
          end
        end
        CMD: begin
          if (i_RX_DV) begin
            if (cmd_rsvd) begin
              o_cmd_err <= 1'b1;
              state     <= DISCARD;
            end else begin
              o_cmd_err <= 1'b0;
              addr      <= cmd_addr;
              if (cmd_rd) begin
                o_TX_Byte <= regs[cmd_addr];
                o_TX_DV   <= 1'b1;
                state     <= READ;
              end else begin
                state <= WRITE;
              end
            end
          end
        end
        WRITE: begin
          if (i_RX_DV) begin
            regs[addr]  <= i_RX_Byte;
            o_wr_strobe <= 1'b1;
            o_wr_addr   <= addr;
            addr        <= addr_nxt;
          end
        end
        READ: begin
          // Incoming byte is a dummy; it only advances the read pointer.
          if (i_RX_DV) begin
            addr      <= addr_nxt;
            o_TX_Byte <= regs[addr_nxt];
            o_TX_DV   <= 1'b1;
          end
        end
        DISCARD: begin
          state <= DISCARD;
        end
        default: begin
          state <= IDLE;
        end
      endcase

      if (state != IDLE) begin
        if (cs_rise) begin
          state <= IDLE;
        end else if (cs_fall) begin
          state <= CMD;
        end
      end
    end
  end

  // Present every register in parallel, reg[n] at bits [8n+7:8n].
  always_comb begin
    o_regs = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      o_regs[8*i +: 8] = regs[i];
    end
  end

endmodule

// File: tb/tb_spi_reg_bank.sv
// Purpose : directed self-checking bench for spi_reg_bank.
// Latency : drives on negedge, samples outputs on the following negedge.
// Backpress: not applicable.
module tb_spi_reg_bank;

  logic        clk;
  logic        rst_n;
  logic        rx_dv;
  logic [7:0]  rx_byte;
  logic        cs_n;
  logic        tx_dv;
  logic [7:0]  tx_byte;
  logic [63:0] regs;
  logic        wr_strobe;
  logic [2:0]  wr_addr;
  logic        cmd_err;

  int tests_run = 0;
  int fails     = 0;
  logic [7:0] exp_regs [8];

  spi_reg_bank #(.NUM_REGS(8), .ADDR_W(3)) dut (
    .i_Clk       (clk),
    .i_Rst_L     (rst_n),
    .i_RX_DV     (rx_dv),
    .i_RX_Byte   (rx_byte),
    .i_SPI_CS_n  (cs_n),
    .o_TX_DV     (tx_dv),
    .o_TX_Byte   (tx_byte),
    .o_regs      (regs),
    .o_wr_strobe (wr_strobe),
    .o_wr_addr   (wr_addr),
    .o_cmd_err   (cmd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] pack_exp();
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v[8*i +: 8] = exp_regs[i];
    return v;
  endfunction

  // One-cycle byte pulse; returns on the negedge after the capturing posedge.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_dv   = 1'b1;
    rx_byte = b;
    @(negedge clk);
    rx_dv   = 1'b0;
  endtask

  task automatic cs_low();
    @(negedge clk);
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_high();
    @(negedge clk);
    cs_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rx_dv = 1'b0; rx_byte = 8'h00; cs_n = 1'b1;
    for (int i = 0; i < 8; i++) exp_regs[i] = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if (regs !== 64'h0) begin fails++; $display("FAIL reset_regs: got %h want %h", regs, 64'h0); end
    tests_run++;
    if ({tx_dv, tx_byte, wr_strobe, wr_addr, cmd_err} !== 14'h0) begin
      fails++; $display("FAIL reset_outs: got %b %h %b %h %b want all zero", tx_dv, tx_byte, wr_strobe, wr_addr, cmd_err);
    end
  endtask

  task automatic test_write();
    cs_low();
    send_byte(8'h02);
    tests_run++;
    if (wr_strobe !== 1'b0) begin fails++; $display("FAIL write_cmd_strobe: got %b want 0", wr_strobe); end
    send_byte(8'h34);
    tests_run++;
    if (wr_strobe !== 1'b1 || wr_addr !== 3'd2) begin fails++; $display("FAIL write_strobe0: got %b/%0d want 1/2", wr_strobe, wr_addr); end
    send_byte(8'h12);
    tests_run++;
    if (wr_strobe !== 1'b1 || wr_addr !== 3'd3) begin fails++; $display("FAIL write_strobe1: got %b/%0d want 1/3", wr_strobe, wr_addr); end
    @(negedge clk);
    tests_run++;
    if (wr_strobe !== 1'b0) begin fails++; $display("FAIL write_strobe_width: got %b want 0", wr_strobe); end
    cs_high();
    exp_regs[2] = 8'h34; exp_regs[3] = 8'h12;
    tests_run++;
    if (regs !== pack_exp()) begin fails++; $display("FAIL write_regs: got %h want %h", regs, pack_exp()); end
  endtask

  task automatic test_read();
    logic [7:0] want [3];
    want = '{8'h34, 8'h12, 8'h00};
    cs_low();
    for (int i = 0; i < 3; i++) begin
      send_byte(i == 0 ? 8'h82 : 8'h5C);
      tests_run++;
      if (tx_dv !== 1'b1 || tx_byte !== want[i] || wr_strobe !== 1'b0) begin
        fails++; $display("FAIL read_%0d: got dv=%b byte=%h strobe=%b want dv=1 byte=%h strobe=0", i, tx_dv, tx_byte, wr_strobe, want[i]);
      end
    end
    @(negedge clk);
    tests_run++;
    if (tx_dv !== 1'b0 || tx_byte !== 8'h00) begin fails++; $display("FAIL read_hold: got dv=%b byte=%h want dv=0 byte=00", tx_dv, tx_byte); end
    cs_high();
    tests_run++;
    if (regs !== pack_exp()) begin fails++; $display("FAIL read_regs: got %h want %h", regs, pack_exp()); end
  endtask

  task automatic test_wrap();
    cs_low();
    send_byte(8'h07);
    send_byte(8'hAA);
    tests_run++;
    if (wr_strobe !== 1'b1 || wr_addr !== 3'd7) begin fails++; $display("FAIL wrap_addr7: got %b/%0d want 1/7", wr_strobe, wr_addr); end
    send_byte(8'hBB);
    tests_run++;
    if (wr_strobe !== 1'b1 || wr_addr !== 3'd0) begin fails++; $display("FAIL wrap_addr0: got %b/%0d want 1/0", wr_strobe, wr_addr); end
    cs_high();
    exp_regs[7] = 8'hAA; exp_regs[0] = 8'hBB;
    tests_run++;
    if (regs !== pack_exp()) begin fails++; $display("FAIL wrap_regs: got %h want %h", regs, pack_exp()); end
  endtask

  task automatic test_bad_cmd();
    cs_low();
    send_byte(8'h48);
    tests_run++;
    if (cmd_err !== 1'b1) begin fails++; $display("FAIL bad_cmd_err: got %b want 1", cmd_err); end
    send_byte(8'hFF);
    tests_run++;
    if (wr_strobe !== 1'b0 || tx_dv !== 1'b0) begin fails++; $display("FAIL bad_cmd_discard: got strobe=%b dv=%b want 0/0", wr_strobe, tx_dv); end
    cs_high();
    tests_run++;
    if (regs !== pack_exp() || cmd_err !== 1'b1) begin fails++; $display("FAIL bad_cmd_regs: got %h err=%b want %h err=1", regs, cmd_err, pack_exp()); end
    // Zero-length transaction leaves everything alone, including the sticky error.
    cs_low();
    cs_high();
    tests_run++;
    if (regs !== pack_exp() || cmd_err !== 1'b1) begin fails++; $display("FAIL zero_len: got %h err=%b want %h err=1", regs, cmd_err, pack_exp()); end
    cs_low();
    send_byte(8'h00);
    tests_run++;
    if (cmd_err !== 1'b0) begin fails++; $display("FAIL cmd_err_clear: got %b want 0", cmd_err); end
    cs_high();
    tests_run++;
    if (regs !== pack_exp()) begin fails++; $display("FAIL clear_regs: got %h want %h", regs, pack_exp()); end
  endtask

  task automatic test_cs_rise_same_cycle();
    cs_low();
    send_byte(8'h01);
    @(negedge clk);
    cs_n = 1'b1;
    // The rise reaches the FSM on the third posedge; land the byte on it.
    @(negedge clk);
    @(negedge clk);
    rx_dv = 1'b1; rx_byte = 8'h5A;
    @(negedge clk);
    rx_dv = 1'b0;
    tests_run++;
    if (wr_strobe !== 1'b1 || wr_addr !== 3'd1) begin fails++; $display("FAIL rise_strobe: got %b/%0d want 1/1", wr_strobe, wr_addr); end
    exp_regs[1] = 8'h5A;
    repeat (3) @(negedge clk);
    send_byte(8'h77);
    tests_run++;
    if (wr_strobe !== 1'b0 || tx_dv !== 1'b0) begin fails++; $display("FAIL idle_byte: got strobe=%b dv=%b want 0/0", wr_strobe, tx_dv); end
    tests_run++;
    if (regs !== pack_exp()) begin fails++; $display("FAIL rise_regs: got %h want %h", regs, pack_exp()); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] wb [4];
    logic [7:0] rb [3];
    wb = '{8'h04, 8'h11, 8'h22, 8'h33};
    rb = '{8'h84, 8'h00, 8'h00};
    cs_low();
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      if (i > 0) begin
        tests_run++;
        if (i == 1) begin
          if (wr_strobe !== 1'b0) begin fails++; $display("FAIL b2b_wcmd: got strobe=%b want 0", wr_strobe); end
        end else if (wr_strobe !== 1'b1 || wr_addr !== 3'(i + 2)) begin
          fails++; $display("FAIL b2b_write_%0d: got %b/%0d want 1/%0d", i - 1, wr_strobe, wr_addr, i + 2);
        end
      end
      if (i < 4) begin rx_dv = 1'b1; rx_byte = wb[i]; end
      else rx_dv = 1'b0;
    end
    cs_high();
    exp_regs[4] = 8'h11; exp_regs[5] = 8'h22; exp_regs[6] = 8'h33;
    tests_run++;
    if (regs !== pack_exp()) begin fails++; $display("FAIL b2b_regs: got %h want %h", regs, pack_exp()); end
    cs_low();
    for (int i = 0; i <= 3; i++) begin
      @(negedge clk);
      if (i > 0) begin
        tests_run++;
        if (tx_dv !== 1'b1 || tx_byte !== wb[i] || wr_strobe !== 1'b0) begin
          fails++; $display("FAIL b2b_read_%0d: got dv=%b byte=%h strobe=%b want 1/%h/0", i - 1, tx_dv, tx_byte, wr_strobe, wb[i]);
        end
      end
      if (i < 3) begin rx_dv = 1'b1; rx_byte = rb[i]; end
      else rx_dv = 1'b0;
    end
    cs_high();
  endtask

  task automatic test_reset_mid_write();
    cs_low();
    send_byte(8'h01);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) exp_regs[i] = 8'h00;
    tests_run++;
    if (regs !== 64'h0 || {tx_dv, tx_byte, wr_strobe, wr_addr, cmd_err} !== 14'h0) begin
      fails++; $display("FAIL rst_mid: got regs=%h dv=%b tx=%h strobe=%b addr=%0d err=%b want all zero", regs, tx_dv, tx_byte, wr_strobe, wr_addr, cmd_err);
    end
    send_byte(8'hC3);
    @(negedge clk);
    rst_n = 1'b1;
    // Byte right after release: FSM is IDLE, no new chip-select fall seen yet.
    rx_dv = 1'b1; rx_byte = 8'h99;
    @(negedge clk);
    rx_dv = 1'b0;
    tests_run++;
    if (wr_strobe !== 1'b0 || tx_dv !== 1'b0) begin fails++; $display("FAIL rst_ignore: got strobe=%b dv=%b want 0/0", wr_strobe, tx_dv); end
    cs_high();
    tests_run++;
    if (regs !== pack_exp()) begin fails++; $display("FAIL rst_regs: got %h want %h", regs, pack_exp()); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_wrap();
    test_bad_cmd();
    test_cs_rise_same_cycle();
    test_back_to_back();
    test_reset_mid_write();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule

// File: doc/spi_reg_bank.md
# spi_reg_bank

Byte-level register file between the SPI slave receiver/transmitter and the display/control logic. It turns the slave's received-byte pulses into framed read/write transactions, delimited by chip select, against a bank of 8-bit registers. It presents every register in parallel, so the 7-segment digit, colon and LED fields are driven from host-written values. On reads it loads the slave's transmit byte with a one-cycle data-valid pulse.

## Interface

Parameters:
- NUM_REGS, 8: register count; must be a power of two, 2..16.
- ADDR_W, 3: address width; must equal log2(NUM_REGS).

Ports:
- i_Clk, input, 1: system clock (WF_CLK domain).
- i_Rst_L, input, 1: reset, asynchronous, active-low.
- i_RX_DV, input, 1: one-cycle pulse from the SPI slave; i_RX_Byte is valid.
- i_RX_Byte, input, 8: received MOSI byte.
- i_SPI_CS_n, input, 1: raw chip-select pin, asynchronous to i_Clk; synchronised internally.
- o_TX_DV, output, 1: one-cycle pulse; slave registers o_TX_Byte for MISO.
- o_TX_Byte, output, 8: read data for the next SPI byte.
- o_regs, output, 8*NUM_REGS: flattened register contents; reg[n] occupies bits [8n+7:8n].
- o_wr_strobe, output, 1: one-cycle pulse per completed register write.
- o_wr_addr, output, ADDR_W: address of the write flagged by o_wr_strobe.
- o_cmd_err, output, 1: sticky flag; set on a bad command; cleared by reset or by a valid command.

## Operation

- CS synchroniser: two flops, reset to 1. cs_sync is the second stage. cs_rise/cs_fall are edges of cs_sync against a third flop.
- State machine states: IDLE, CMD, WRITE, READ, DISCARD.
  - IDLE: on cs_fall, go to CMD.
  - CMD: the first i_RX_DV is the command byte. Bit 7: 1 = read, 0 = write. Bits [ADDR_W-1:0]: start address. Bits [6:ADDR_W]: reserved, must be 0.
    - Reserved bits nonzero: set o_cmd_err, go to DISCARD.
    - Valid read: clear o_cmd_err, latch addr, load o_TX_Byte = reg[addr], pulse o_TX_DV, go to READ.
    - Valid write: clear o_cmd_err, latch addr, go to WRITE.
  - WRITE: each i_RX_DV does reg[addr] <= i_RX_Byte, pulses o_wr_strobe with o_wr_addr = addr, then addr <= addr+1.
  - READ: each i_RX_DV (dummy byte, content ignored) does addr <= addr+1, loads o_TX_Byte = reg[addr+1], pulses o_TX_DV.
  - DISCARD: ignore all bytes.
- Any state except IDLE: cs_rise returns the FSM to IDLE. If i_RX_DV occurs in the same cycle as cs_rise, the byte is processed first, then the FSM goes to IDLE.
- cs_fall while not in IDLE: restart in CMD (previous transaction abandoned).
- i_RX_DV in IDLE (CS high): ignored, no side effects.
- Address arithmetic is ADDR_W bits and wraps modulo NUM_REGS (addr 7+1 = 0).
- A zero-length transaction (CS low then high, no bytes) has no effect.
- Reset: all registers 0x00, o_TX_Byte = 0x00, o_TX_DV = 0, o_wr_strobe = 0, o_wr_addr = 0, o_cmd_err = 0, FSM in IDLE, CS sync flops = 1.

## Timing

- CS latency: pin edge to FSM reaction is 3 i_Clk cycles.
- Write: reg[n] and o_regs update on the clock edge after the i_RX_DV cycle. o_wr_strobe is high during that following cycle.
- Read: o_TX_DV and o_TX_Byte become valid 1 cycle after the i_RX_DV that triggered them. o_TX_Byte holds until the next load.
- o_TX_DV and o_wr_strobe are never high for more than 1 consecutive cycle. They are never asserted simultaneously.
- Back-to-back i_RX_DV on consecutive cycles: each pulse is handled; no byte is dropped.
- Read data reflects register contents at the i_RX_DV cycle. A write in a prior transaction is always visible.

## Test plan

- Reset, then write transaction: bytes 0x02, 0x34, 0x12 → reg2 = 0x34, reg3 = 0x12; o_wr_strobe pulses with o_wr_addr = 2 then 3; other registers stay 0x00.
- Read transaction: 0x82 plus two dummy bytes → o_TX_DV pulses 3 times carrying 0x34, 0x12, 0x00, each 1 cycle after its i_RX_DV.
- Wrap: write 0x07, 0xAA, 0xBB → reg7 = 0xAA, reg0 = 0xBB.
- Bad command 0x48 followed by 0xFF → o_cmd_err = 1, no register change; next command 0x00 clears o_cmd_err.
- CS rise in the same cycle as the last i_RX_DV (write 0x01, 0x5A) → reg1 = 0x5A, FSM in IDLE. Then i_RX_DV 0x77 with CS high → no change.
- i_Rst_L asserted mid-write after the command byte → all outputs at reset values immediately. Subsequent bytes are ignored until a new cs_fall.
